mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data wins contention except every fourth consecutive grant, which goes to fetch.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_half,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_err,
  output logic        mem_en,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  skip_cnt_q, skip_cnt_d;
  logic        mem_en_q, mem_en_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_ready_q, d_ready_d;
  logic        d_err_q, d_err_d;
  logic        we_q, we_d;
  logic        half_q, half_d;
  logic        hi_q, hi_d;
  logic        mis_q, mis_d;

  logic take_data;
  logic d_mis;
  logic unused_if_lsbs;

  function automatic logic misaligned(input logic half, input logic [1:0] a);
    return half ? a[0] : (a != 2'b00);
  endfunction

  function automatic logic [31:0] sext_half(input logic signed [15:0] h);
    return 32'(h);
  endfunction

  function automatic logic [31:0] load_data(input logic half, input logic hi,
                                            input logic [31:0] w);
    if (!half) return w;
    return hi ? sext_half(w[31:16]) : sext_half(w[15:0]);
  endfunction

  assign unused_if_lsbs = ^if_addr[1:0];
  assign take_data = d_req && !(if_req && skip_cnt_q == 2'd3);
  assign d_mis     = misaligned(d_half, d_addr[1:0]);

  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    mem_en_d    = mem_en_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    if_ready_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_ready_d   = 1'b0;
    d_err_d     = d_err_q;
    we_d        = we_q;
    half_d      = half_q;
    hi_d        = hi_q;
    mis_d       = mis_q;
    case (state_q)
      IDLE: begin
        if (take_data) begin
          state_d    = DATA;
          if (if_req && skip_cnt_q != 2'd3) skip_cnt_d = skip_cnt_q + 2'd1;
          we_d       = d_we;
          half_d     = d_half;
          hi_d       = d_addr[1];
          mis_d      = d_mis;
          mem_addr_d = {d_addr[31:2], 2'b00};
          // A misaligned access still passes through DATA so d_ready keeps normal latency.
          mem_en_d   = !d_mis;
          if (d_we && !d_mis)
            mem_be_d = d_half ? (d_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
          else
            mem_be_d = 4'b0000;
          if (d_we)
            mem_wdata_d = d_half ? {d_wdata[15:0], d_wdata[15:0]} : d_wdata;
          else
            mem_wdata_d = 32'd0;
        end else if (if_req) begin
          state_d     = FETCH;
          skip_cnt_d  = 2'd0;
          mem_en_d    = 1'b1;
          mem_be_d    = 4'b0000;
          mem_addr_d  = {if_addr[31:2], 2'b00};
          mem_wdata_d = 32'd0;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          state_d    = DONE;
          mem_en_d   = 1'b0;
          mem_be_d   = 4'b0000;
          if_rdata_d = mem_rdata;
          if_ready_d = 1'b1;
          d_err_d    = 1'b0;
        end
      end
      DATA: begin
        if (mis_q) begin
          state_d   = DONE;
          d_ready_d = 1'b1;
          d_err_d   = 1'b1;
          d_rdata_d = 32'd0;
        end else if (mem_ack) begin
          state_d   = DONE;
          mem_en_d  = 1'b0;
          mem_be_d  = 4'b0000;
          d_ready_d = 1'b1;
          d_err_d   = 1'b0;
          if (!we_q) d_rdata_d = load_data(half_q, hi_q, mem_rdata);
        end
      end
      DONE: begin
        // Requests are ignored here so a requester still holding req is not re-granted.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      skip_cnt_q  <= 2'd0;
      mem_en_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      if_ready_q  <= 1'b0;
      d_rdata_q   <= 32'd0;
      d_ready_q   <= 1'b0;
      d_err_q     <= 1'b0;
      we_q        <= 1'b0;
      half_q      <= 1'b0;
      hi_q        <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_ready_q  <= if_ready_d;
      d_rdata_q   <= d_rdata_d;
      d_ready_q   <= d_ready_d;
      d_err_q     <= d_err_d;
      we_q        <= we_d;
      half_q      <= half_d;
      hi_q        <= hi_d;
      mis_q       <= mis_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_err     = d_err_q;
  assign mem_en    = mem_en_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall     = (if_req | d_req) & ~(if_ready_q | d_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order and access results.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, d_half, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, d_err, mem_en, stall;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_fail   = 0;
  int skip_m   = 0;
  logic [31:0] if_rdata_m = '0;
  logic [31:0] d_rdata_m  = '0;
  logic        d_err_m    = 1'b0;
  logic        d_known    = 1'b1;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_half(d_half), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
    .mem_en(mem_en), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_half = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
  endtask

  function automatic logic [31:0] half_model(input logic [15:0] h);
    int v;
    v = int'(h);
    if (v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    tick(); tick();
    n_checks++;
    if ({if_rdata, if_ready, d_rdata, d_ready, d_err, mem_en, mem_be, mem_addr, mem_wdata, stall} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0",
               {if_rdata, if_ready, d_rdata, d_ready, d_err, mem_en, mem_be, mem_addr, mem_wdata, stall});
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({mem_en, if_ready, d_ready, stall} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b, required 0000", {mem_en, if_ready, d_ready, stall});
    end
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    #1;
    n_checks++;
    if (stall !== 1'b1 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_cycle0: got stall=%b mem_en=%b, required stall=1 mem_en=0", stall, mem_en);
    end
    tick();
    n_checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h0000_0040 || mem_be !== 4'b0000) begin
      n_fail++;
      $display("FAIL fetch_cmd: got en=%b addr=%h be=%b, required en=1 addr=00000040 be=0000", mem_en, mem_addr, mem_be);
    end
    mem_ack = 1'b1; mem_rdata = 32'h2108_0001;
    tick();
    mem_ack = 1'b0;
    n_checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h2108_0001 || d_ready !== 1'b0 || mem_en !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_done: got rdy=%b rdata=%h drdy=%b en=%b stall=%b, required 1 21080001 0 0 0",
               if_ready, if_rdata, d_ready, mem_en, stall);
    end
    if_req = 1'b0;
    if_rdata_m = 32'h2108_0001; skip_m = 0;
    tick();
    n_checks++;
    if (if_ready !== 1'b0 || if_rdata !== 32'h2108_0001) begin
      n_fail++;
      $display("FAIL fetch_pulse_hold: got rdy=%b rdata=%h, required 0 21080001", if_ready, if_rdata);
    end
  endtask

  task automatic test_half_load();
    logic [31:0] addrs [3];
    logic [31:0] rds [3];
    logic [31:0] exps [3];
    addrs = '{32'h0000_0102, 32'h0000_0100, 32'h0000_0106};
    rds   = '{32'h8001_1234, 32'h1234_9ABC, 32'h7FFF_8000};
    exps  = '{32'hFFFF_8001, 32'hFFFF_9ABC, 32'h0000_7FFF};
    for (int i = 0; i < 3; i++) begin
      d_req = 1'b1; d_half = 1'b1; d_we = 1'b0; d_addr = addrs[i];
      tick();
      n_checks++;
      if (mem_en !== 1'b1 || mem_addr !== (addrs[i] & 32'hFFFF_FFFC) || mem_be !== 4'b0000) begin
        n_fail++;
        $display("FAIL hload_cmd[%0d]: got en=%b addr=%h be=%b, required en=1 addr=%h be=0000",
                 i, mem_en, mem_addr, mem_be, addrs[i] & 32'hFFFF_FFFC);
      end
      mem_ack = 1'b1; mem_rdata = rds[i];
      tick();
      mem_ack = 1'b0;
      n_checks++;
      if (d_ready !== 1'b1 || d_rdata !== exps[i] || d_err !== 1'b0) begin
        n_fail++;
        $display("FAIL hload_data[%0d]: got rdy=%b rdata=%h err=%b, required 1 %h 0", i, d_ready, d_rdata, d_err, exps[i]);
      end
      d_req = 1'b0;
      tick();
    end
    d_rdata_m = exps[2]; d_known = 1'b1; d_err_m = 1'b0;
  endtask

  task automatic test_half_store();
    logic        halves [3];
    logic [31:0] addrs [3];
    logic [31:0] wds [3];
    logic [3:0]  bes [3];
    logic [31:0] expw [3];
    halves = '{1'b1, 1'b1, 1'b0};
    addrs  = '{32'h0000_0200, 32'h0000_0202, 32'h0000_0204};
    wds    = '{32'h0000_ABCD, 32'h1234_5678, 32'hDEAD_BEEF};
    bes    = '{4'b0011, 4'b1100, 4'b1111};
    expw   = '{32'hABCD_ABCD, 32'h5678_5678, 32'hDEAD_BEEF};
    for (int i = 0; i < 3; i++) begin
      d_req = 1'b1; d_we = 1'b1; d_half = halves[i]; d_addr = addrs[i]; d_wdata = wds[i];
      tick();
      for (int w = 0; w < 2; w++) begin
        n_checks++;
        if (mem_en !== 1'b1 || mem_addr !== (addrs[i] & 32'hFFFF_FFFC) || mem_be !== bes[i] || mem_wdata !== expw[i]) begin
          n_fail++;
          $display("FAIL store_cmd[%0d.%0d]: got en=%b addr=%h be=%b wdata=%h, required 1 %h %b %h",
                   i, w, mem_en, mem_addr, mem_be, mem_wdata, addrs[i] & 32'hFFFF_FFFC, bes[i], expw[i]);
        end
        if (w == 1) mem_ack = 1'b1;
        tick();
      end
      mem_ack = 1'b0;
      n_checks++;
      if (d_ready !== 1'b1 || d_err !== 1'b0 || mem_en !== 1'b0 || mem_be !== 4'b0000) begin
        n_fail++;
        $display("FAIL store_done[%0d]: got rdy=%b err=%b en=%b be=%b, required 1 0 0 0000", i, d_ready, d_err, mem_en, mem_be);
      end
      d_req = 1'b0;
      tick();
    end
    d_we = 1'b0; d_known = 1'b0; d_err_m = 1'b0;
  endtask

  task automatic test_misaligned();
    logic        halves [3];
    logic        wes [3];
    logic [31:0] addrs [3];
    halves = '{1'b1, 1'b0, 1'b0};
    wes    = '{1'b0, 1'b1, 1'b0};
    addrs  = '{32'h0000_0101, 32'h0000_0102, 32'h0000_0203};
    for (int i = 0; i < 3; i++) begin
      d_req = 1'b1; d_half = halves[i]; d_we = wes[i]; d_addr = addrs[i]; d_wdata = 32'h5555_AAAA;
      tick();
      n_checks++;
      if (mem_en !== 1'b0 || mem_be !== 4'b0000 || d_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL mis_noaccess[%0d]: got en=%b be=%b rdy=%b, required 0 0000 0", i, mem_en, mem_be, d_ready);
      end
      tick();
      n_checks++;
      if (d_ready !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'd0 || mem_en !== 1'b0) begin
        n_fail++;
        $display("FAIL mis_done[%0d]: got rdy=%b err=%b rdata=%h en=%b, required 1 1 00000000 0", i, d_ready, d_err, d_rdata, mem_en);
      end
      d_req = 1'b0;
      tick();
      n_checks++;
      if (d_ready !== 1'b0 || d_err !== 1'b1) begin
        n_fail++;
        $display("FAIL mis_err_hold[%0d]: got rdy=%b err=%b, required 0 1", i, d_ready, d_err);
      end
    end
    d_we = 1'b0; d_half = 1'b0;
    d_err_m = 1'b1; d_rdata_m = 32'd0; d_known = 1'b1;
  endtask

  task automatic test_contention();
    bit          is_fetch [8];
    logic [31:0] rd;
    is_fetch = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    if_req = 1'b1; if_addr = 32'h0000_1006;
    d_req = 1'b1; d_we = 1'b0; d_half = 1'b0; d_addr = 32'h0000_2008;
    for (int i = 0; i < 8; i++) begin
      tick();
      rd = $urandom();
      mem_ack = 1'b1; mem_rdata = rd;
      n_checks++;
      if (mem_en !== 1'b1 || mem_addr !== (is_fetch[i] ? 32'h0000_1004 : 32'h0000_2008)) begin
        n_fail++;
        $display("FAIL contend_grant[%0d]: got en=%b addr=%h, required fetch=%0d", i, mem_en, mem_addr, is_fetch[i]);
      end
      tick();
      mem_ack = 1'b0;
      n_checks++;
      if ({if_ready, d_ready} !== {is_fetch[i], !is_fetch[i]}) begin
        n_fail++;
        $display("FAIL contend_ready[%0d]: got if=%b d=%b, required if=%0d", i, if_ready, d_ready, is_fetch[i]);
      end
      n_checks++;
      if (is_fetch[i] ? (if_rdata !== rd) : (d_rdata !== rd || d_err !== 1'b0)) begin
        n_fail++;
        $display("FAIL contend_data[%0d]: got if=%h d=%h err=%b, required %h", i, if_rdata, d_rdata, d_err, rd);
      end
      if (is_fetch[i]) if_rdata_m = rd;
      else d_rdata_m = rd;
      if (i == 7) begin if_req = 1'b0; d_req = 1'b0; end
      tick();
    end
    d_err_m = 1'b0; d_known = 1'b1; skip_m = 0;
  endtask

  task automatic test_reset_mid_access();
    d_req = 1'b1; d_we = 1'b0; d_half = 1'b0; d_addr = 32'h0000_0300;
    tick(); tick();
    n_checks++;
    if (mem_en !== 1'b1 || d_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_pending: got en=%b rdy=%b, required 1 0", mem_en, d_ready);
    end
    #2;
    rst = 1'b0; d_req = 1'b0;
    #1;
    n_checks++;
    if ({if_rdata, if_ready, d_rdata, d_ready, d_err, mem_en, mem_be, mem_addr, mem_wdata, stall} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: got %h, required 0",
               {if_rdata, if_ready, d_rdata, d_ready, d_err, mem_en, mem_be, mem_addr, mem_wdata, stall});
    end
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({mem_en, d_ready, if_ready, d_err} !== 4'b0000 || d_rdata !== 32'd0 || if_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL rstmid_late_ack: got en=%b drdy=%b irdy=%b err=%b drd=%h ird=%h, required all 0",
               mem_en, d_ready, if_ready, d_err, d_rdata, if_rdata);
    end
    mem_ack = 1'b0;
    if_rdata_m = '0; d_rdata_m = '0; d_err_m = 1'b0; d_known = 1'b1; skip_m = 0;
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0500;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release_nogrant: got en=%b, required 0", mem_en);
    end
    tick();
    n_checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h0000_0500) begin
      n_fail++;
      $display("FAIL rst_first_grant: got en=%b addr=%h, required 1 00000500", mem_en, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ack = 1'b0;
    n_checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL rst_first_done: got rdy=%b rdata=%h, required 1 0badf00d", if_ready, if_rdata);
    end
    if_rdata_m = 32'h0BAD_F00D;
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic        f_pend, d_pend, dwe, dhalf, grant_d, mis;
    logic [31:0] fa, da, dw, exp_addr, exp_wdata, rd, exp_rd;
    logic [3:0]  exp_be;
    int          nw;
    f_pend = 1'b0; d_pend = 1'b0; fa = '0; da = '0; dw = '0; dwe = 1'b0; dhalf = 1'b0; rd = '0;
    for (int t = 0; t < 80; t++) begin
      if (!f_pend && $urandom_range(0, 9) < 6) begin f_pend = 1'b1; fa = $urandom(); end
      if (!d_pend && $urandom_range(0, 9) < 7) begin
        d_pend = 1'b1; da = $urandom(); dw = $urandom();
        dwe = 1'($urandom_range(0, 1)); dhalf = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) != 0) da[1:0] = dhalf ? {da[1], 1'b0} : 2'b00;
      end
      if (!f_pend && !d_pend) begin f_pend = 1'b1; fa = $urandom(); end
      if_req = f_pend; if_addr = fa;
      d_req = d_pend; d_addr = da; d_wdata = dw; d_we = dwe; d_half = dhalf;
      mem_ack = ($urandom_range(0, 3) == 0); mem_rdata = $urandom();
      grant_d = d_pend && !(f_pend && skip_m == 3);
      if (grant_d) begin
        if (f_pend && skip_m < 3) skip_m++;
      end else begin
        skip_m = 0;
      end
      mis = grant_d && (dhalf ? da[0] : (da[1:0] != 2'b00));
      exp_addr = (grant_d ? da : fa) & 32'hFFFF_FFFC;
      exp_be = (grant_d && dwe) ? (dhalf ? (da[1] ? 4'b1100 : 4'b0011) : 4'b1111) : 4'b0000;
      exp_wdata = dhalf ? {dw[15:0], dw[15:0]} : dw;
      tick();
      mem_ack = 1'b0;
      if (mis) begin
        n_checks++;
        if ({mem_en, mem_be, if_ready, d_ready} !== 7'd0) begin
          n_fail++;
          $display("FAIL rnd_mis_noaccess[%0d]: got en=%b be=%b rdy=%b%b, required zeros", t, mem_en, mem_be, if_ready, d_ready);
        end
        tick();
        n_checks++;
        if ({d_ready, d_err, if_ready} !== 3'b110 || d_rdata !== 32'd0) begin
          n_fail++;
          $display("FAIL rnd_mis_done[%0d]: got drdy=%b err=%b irdy=%b rdata=%h, required 1 1 0 0", t, d_ready, d_err, if_ready, d_rdata);
        end
        d_err_m = 1'b1; d_rdata_m = '0; d_known = 1'b1;
      end else begin
        nw = $urandom_range(0, 3);
        for (int w = 0; w <= nw; w++) begin
          if (w == nw) begin rd = $urandom(); mem_ack = 1'b1; mem_rdata = rd; end
          else begin mem_ack = 1'b0; mem_rdata = $urandom(); end
          n_checks++;
          if (mem_en !== 1'b1 || mem_addr !== exp_addr || mem_be !== exp_be || {if_ready, d_ready} !== 2'b00 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL rnd_cmd[%0d]: got en=%b addr=%h be=%b rdy=%b%b stall=%b, required 1 %h %b 00 1",
                     t, mem_en, mem_addr, mem_be, if_ready, d_ready, stall, exp_addr, exp_be);
          end
          if (grant_d && dwe) begin
            n_checks++;
            if (mem_wdata !== exp_wdata) begin
              n_fail++;
              $display("FAIL rnd_wdata[%0d]: got %h, required %h", t, mem_wdata, exp_wdata);
            end
          end
          n_checks++;
          if (if_rdata !== if_rdata_m || d_err !== d_err_m || (d_known && d_rdata !== d_rdata_m)) begin
            n_fail++;
            $display("FAIL rnd_hold[%0d]: got ird=%h drd=%h err=%b, required %h %h %b", t, if_rdata, d_rdata, d_err, if_rdata_m, d_rdata_m, d_err_m);
          end
          tick();
        end
        mem_ack = 1'b0;
        if (grant_d) begin
          d_err_m = 1'b0;
          if (!dwe) begin
            exp_rd = dhalf ? half_model(da[1] ? rd[31:16] : rd[15:0]) : rd;
            d_rdata_m = exp_rd; d_known = 1'b1;
          end else begin
            d_known = 1'b0;
          end
        end else begin
          if_rdata_m = rd; d_err_m = 1'b0;
        end
        n_checks++;
        if ({if_ready, d_ready} !== {!grant_d, grant_d} || mem_en !== 1'b0 || mem_be !== 4'b0000) begin
          n_fail++;
          $display("FAIL rnd_done[%0d]: got rdy=%b%b en=%b be=%b, required data=%b", t, if_ready, d_ready, mem_en, mem_be, grant_d);
        end
        n_checks++;
        if (if_rdata !== if_rdata_m || d_err !== d_err_m || (d_known && d_rdata !== d_rdata_m)) begin
          n_fail++;
          $display("FAIL rnd_data[%0d]: got ird=%h drd=%h err=%b, required %h %h %b", t, if_rdata, d_rdata, d_err, if_rdata_m, d_rdata_m, d_err_m);
        end
      end
      n_checks++;
      if (stall !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_stall_done[%0d]: got %b, required 0", t, stall);
      end
      if (grant_d) d_pend = 1'b0;
      else f_pend = 1'b0;
      if_req = f_pend; d_req = d_pend;
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom();
      tick();
      mem_ack = 1'b0;
      n_checks++;
      if ({if_ready, d_ready} !== 2'b00 || mem_en !== 1'b0 || d_err !== d_err_m) begin
        n_fail++;
        $display("FAIL rnd_idle[%0d]: got rdy=%b%b en=%b err=%b, required 00 0 %b", t, if_ready, d_ready, mem_en, d_err, d_err_m);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_half_load();
    test_half_store();
    test_misaligned();
    test_contention();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
